// File: rtl/heart_mon_pkg.sv
// Shared definitions for the heart count receiver/checker.
//
// Contents:
//   HEART_MAX - highest legal value on the 4-bit heart count bus
//   state_e   - monitor state encoding (visible on state_dbg)
//   step_e    - classification of one sample against the previous one
//
// Optional feature macro used by the monitor: HEART_MON_LED_EN.

package heart_mon_pkg;

    localparam int unsigned HEART_MAX = 7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StLocked  = 2'd2,
        StLost    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        StepUp      = 3'd0,
        StepDown    = 3'd1,
        StepHold    = 3'd2,
        StepJump    = 3'd3,
        StepIllegal = 3'd4
    } step_e;

endpackage

// File: rtl/heart_step_classify.sv
// Combinational classification of the current heart count sample against the
// previously accepted one. Arithmetic is modulo 8, so 7->0 is an up step and
// 0->7 is a down step.
//
// Ports:
//   cur  - raw 4-bit sample from the bus (values above HEART_MAX are illegal)
//   prev - last legal sample
//   step - resulting step class

module heart_step_classify
    import heart_mon_pkg::*;
(
    input  logic [3:0] cur,
    input  logic [2:0] prev,
    output step_e      step
);

    always_comb begin
        step = StepJump;
        if (cur > 4'(HEART_MAX)) begin
            step = StepIllegal;
        end else if (cur[2:0] == prev + 3'd1) begin
            step = StepUp;
        end else if (cur[2:0] == prev - 3'd1) begin
            step = StepDown;
        end else if (cur[2:0] == prev) begin
            step = StepHold;
        end
    end

endmodule

// File: rtl/heart_beat_monitor.sv
// Receiver/checker for the 4-bit heart count bus, sampled on the 1 Hz tick.
// Tracks the 0..7 wrap-around sequence, infers its direction, declares lock
// after LOCK_CNT consistent steps, flags illegal values, jumps, stalls and
// reversals, and counts completed laps while locked.
//
// Optional feature: define HEART_MON_LED_EN to drive a registered active-low
// one-hot position decode on led_n. Without it led_n is tied to 8'hFF.
//
// Ports:
//   clk_1hz_in - 1 Hz sample clock
//   rst_n_in   - asynchronous, active-low reset
//   heart_cnt  - count under observation, legal values 0..7
//   dir_out    - tracked direction, 1 = incrementing
//   locked     - high while in the locked state
//   err_pulse  - one-cycle pulse on an illegal value or jump
//   rev_pulse  - one-cycle pulse on an accepted reversal while locked
//   lap_cnt    - laps completed while locked, wraps modulo 2^LAP_W
//   state_dbg  - current state encoding
//   led_n      - active-low one-hot position LEDs

module heart_beat_monitor
    import heart_mon_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_MAX   = 2,
    parameter int unsigned STALL_MAX = 4,
    parameter int unsigned LAP_W     = 8
) (
    input  logic             clk_1hz_in,
    input  logic             rst_n_in,
    input  logic [3:0]       heart_cnt,
    output logic             dir_out,
    output logic             locked,
    output logic             err_pulse,
    output logic             rev_pulse,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [1:0]       state_dbg,
    output logic [7:0]       led_n
);

    localparam logic [3:0] LOCK_LIM  = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_LIM   = 4'(ERR_MAX);
    localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);
    localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};

    state_e     state;
    logic [2:0] prev;
    logic       cand_dir;
    logic [3:0] run_cnt;
    logic [3:0] err_cnt;
    logic [3:0] stall_cnt;

    step_e      step;
    logic       legal;
    logic       step_up;
    logic       wrap;
    logic [3:0] run_next;
    logic [3:0] err_next;
    logic [3:0] stall_next;

    heart_step_classify u_classify (
        .cur  (heart_cnt),
        .prev (prev),
        .step (step)
    );

    always_comb begin
        legal      = (step != StepIllegal);
        step_up    = (step == StepUp);
        // Only meaningful for up/down steps: crossing the 7/0 boundary.
        wrap       = (step == StepUp   && heart_cnt[2:0] == 3'd0) ||
                     (step == StepDown && heart_cnt[2:0] == 3'd7);
        // A step against the candidate direction starts a new run of length one.
        run_next   = (step_up == cand_dir) ? run_cnt + 4'd1 : 4'd1;
        err_next   = err_cnt + 4'd1;
        stall_next = stall_cnt + 4'd1;
    end

    assign state_dbg = state;

    always_ff @(posedge clk_1hz_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= StIdle;
            prev      <= 3'd0;
            cand_dir  <= 1'b0;
            dir_out   <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            rev_pulse <= 1'b0;
            lap_cnt   <= '0;
            run_cnt   <= 4'd0;
            err_cnt   <= 4'd0;
            stall_cnt <= 4'd0;
        end else begin
            err_pulse <= 1'b0;
            rev_pulse <= 1'b0;
            if (legal) begin
                prev <= heart_cnt[2:0];
            end

            unique case (state)
                StIdle: begin
                    if (legal) begin
                        state   <= StAcquire;
                        run_cnt <= 4'd0;
                    end else begin
                        err_pulse <= 1'b1;
                    end
                end

                StAcquire: begin
                    unique case (step)
                        StepUp, StepDown: begin
                            cand_dir <= step_up;
                            run_cnt  <= run_next;
                            if (run_next == LOCK_LIM) begin
                                state     <= StLocked;
                                dir_out   <= step_up;
                                locked    <= 1'b1;
                                err_cnt   <= 4'd0;
                                stall_cnt <= 4'd0;
                            end
                        end
                        StepHold: begin
                        end
                        default: begin
                            err_pulse <= 1'b1;
                            run_cnt   <= 4'd0;
                        end
                    endcase
                end

                StLocked: begin
                    unique case (step)
                        StepUp, StepDown: begin
                            err_cnt   <= 4'd0;
                            stall_cnt <= 4'd0;
                            if (step_up == dir_out) begin
                                if (wrap) begin
                                    lap_cnt <= lap_cnt + LAP_ONE;
                                end
                            end else begin
                                // Reversal wins over a simultaneous wrap.
                                dir_out   <= step_up;
                                cand_dir  <= step_up;
                                rev_pulse <= 1'b1;
                            end
                        end
                        StepHold: begin
                            stall_cnt <= stall_next;
                            if (stall_next == STALL_LIM) begin
                                state  <= StLost;
                                locked <= 1'b0;
                            end
                        end
                        default: begin
                            err_pulse <= 1'b1;
                            err_cnt   <= err_next;
                            if (err_next == ERR_LIM) begin
                                state  <= StLost;
                                locked <= 1'b0;
                            end
                        end
                    endcase
                end

                StLost: begin
                    // One-cycle pause; this sample only refreshes prev.
                    state     <= StAcquire;
                    run_cnt   <= 4'd0;
                    err_cnt   <= 4'd0;
                    stall_cnt <= 4'd0;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef HEART_MON_LED_EN
    always_ff @(posedge clk_1hz_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            led_n <= 8'hFF;
        end else if (legal) begin
            led_n <= ~(8'b1 << heart_cnt[2:0]);
        end
    end
`else
    assign led_n = 8'hFF;
`endif

endmodule

// File: doc/heart_beat_monitor.md
Name: heart_beat_monitor

Overview:
Receiver/checker at the consuming end of the 4-bit heart count bus, sampled on the same 1 Hz tick.
- Tracks the 0..7 wrap-around sequence and infers count direction.
- Declares lock once the sequence is consistent, and flags illegal values, jumps, stalls and direction reversals.
- Counts completed laps and, optionally, decodes the position onto the board LEDs.

Parameters:
LOCK_CNT, 3, consecutive same-direction steps needed to enter LOCKED (1..15)
ERR_MAX, 2, consecutive bad steps in LOCKED that force LOST (1..15)
STALL_MAX, 4, consecutive hold steps in LOCKED that force LOST (1..15)
LAP_W, 8, width of lap counter

Ports:
clk_1hz_in  input  1  1 Hz sample clock
rst_n_in  input  1  asynchronous, active-low reset
heart_cnt  input  4  count under observation; legal values 0..7
dir_out  output  1  tracked direction: 1 = incrementing, 0 = decrementing
locked  output  1  high while in LOCKED
err_pulse  output  1  one-cycle pulse on illegal value or jump
rev_pulse  output  1  one-cycle pulse on accepted direction reversal in LOCKED
lap_cnt  output  LAP_W  laps completed while LOCKED, wraps modulo 2^LAP_W
state_dbg  output  2  current state encoding
led_n  output  8  active-low one-hot position LEDs (see Optional Feature)

Behaviour:
- Interface: reset rst_n_in, asynchronous, active-low; clock clk_1hz_in.
- Reset: state=IDLE, prev=0, cand_dir=0, dir_out=0, locked=0, err_pulse=0, rev_pulse=0, lap_cnt=0, run_cnt=0, err_cnt=0, stall_cnt=0, led_n=8'hFF.
- Reset mid-operation aborts immediately with no partial update.
- All outputs are registered. A classification made at edge N is visible after edge N.
- Step classification on each edge, comparing heart_cnt (cur) with prev, both mod 8:
  - ILLEGAL if cur>7.
  - UP if cur==prev+1.
  - DOWN if cur==prev-1.
  - HOLD if cur==prev.
  - JUMP otherwise.
- prev loads cur on every non-ILLEGAL sample.
- The wrap cases 7->0 (UP) and 0->7 (DOWN) are legal steps.
- States: IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.
- IDLE:
  - Legal cur: store it, go to ACQUIRE, run_cnt=0.
  - ILLEGAL: err_pulse, stay in IDLE.
- ACQUIRE:
  - UP/DOWN matching cand_dir: run_cnt+1.
  - UP/DOWN opposite to cand_dir: cand_dir flips, run_cnt=1.
  - HOLD: no change.
  - JUMP/ILLEGAL: err_pulse, run_cnt=0.
  - When the increment makes run_cnt reach LOCK_CNT on that edge: go to LOCKED, dir_out=cand_dir, locked=1. err_cnt and stall_cnt clear.
  - With LOCK_CNT=1, the first valid step locks.
- LOCKED:
  - Step in dir_out direction: clears err_cnt and stall_cnt. A 7->0 (UP) or 0->7 (DOWN) step increments lap_cnt.
  - Opposite step: dir_out and cand_dir flip, rev_pulse, stay LOCKED, counters clear, no lap increment (even across a wrap).
  - HOLD: stall_cnt+1. Reaching STALL_MAX goes to LOST.
  - JUMP/ILLEGAL: err_pulse, err_cnt+1. Reaching ERR_MAX goes to LOST.
- LOST:
  - locked=0 on entry.
  - Stays exactly one cycle. The next edge goes to ACQUIRE with run_cnt=0 and all counters cleared; that sample only updates prev.
  - lap_cnt and dir_out hold their values.
- Simultaneous events: a reversal coinciding with a wrap counts as a reversal only.

Optional Feature:
- Macro HEART_MON_LED_EN.
- Defined: led_n = ~(8'b1 << prev), registered. It updates on each legal sample in every state except IDLE-after-reset (before the first legal sample it stays 8'hFF). ILLEGAL samples leave led_n unchanged.
- Undefined: led_n is the constant 8'hFF and no decode logic is built. The port is always present.

Decomposition:
- Package heart_mon_pkg:
  - state encoding constants (IDLE/ACQUIRE/LOCKED/LOST)
  - step class constants (UP/DOWN/HOLD/JUMP/ILLEGAL)
  - HEART_MAX=7
- Sub-module heart_step_classify: combinational classification of cur vs prev. The monitor instantiates it once.

Test Plan:
1. Reset, then drive 0,1,2,3,4,... with defaults -> locked=1 after the edge sampling 3, dir_out=1; lap_cnt=1 after the 7->0 step.
2. Locked UP, then drive 4,3,2 -> rev_pulse on the edge sampling 3, dir_out=0, locked stays 1; the next 0->7 step gives lap_cnt+1.
3. Locked, then drive 4,6,1 (two jumps) -> err_pulse on 6 and on 1, LOST after the second. The next edge gives ACQUIRE, locked=0, lap_cnt retained.
4. Locked at 5, then hold 5 four times -> state LOST after the fourth hold. Resume 6,7,0,1 -> re-lock after 3 steps, lap unchanged while unlocked.
5. Drive 9 in IDLE and mid-LOCKED -> err_pulse, prev unchanged, led_n unchanged (LED_EN). A single 9 between good steps does not lose lock with ERR_MAX=2.
6. Assert rst_n_in low mid-lap with lap_cnt=3 -> all outputs return to reset values asynchronously, led_n=8'hFF.
